// File: rtl/fht_but_array_if.sv
// rtl/fht_but_array_if.sv - handshake/data bundle for the FHT butterfly array
interface fht_but_array_if #(
  parameter int D_BIT = 17,
  parameter int W_BIT = 12,
  parameter int N_BUT = 2
);
  logic                     iVALID;
  logic [1:0]               iMODE;
  logic                     iSCALE;
  logic [N_BUT*D_BIT-1:0]   iX_0;
  logic [N_BUT*D_BIT-1:0]   iX_1;
  logic [N_BUT*D_BIT-1:0]   iX_2;
  logic [N_BUT*W_BIT-1:0]   iCOS;
  logic [N_BUT*W_BIT-1:0]   iSIN;
  logic                     iOVF_CLR;
  logic                     oVALID;
  logic [N_BUT*D_BIT-1:0]   oA;
  logic [N_BUT*D_BIT-1:0]   oB;
  logic                     oOVF;

  modport master (
    output iVALID, iMODE, iSCALE, iX_0, iX_1, iX_2, iCOS, iSIN, iOVF_CLR,
    input  oVALID, oA, oB, oOVF
  );

  modport slave (
    input  iVALID, iMODE, iSCALE, iX_0, iX_1, iX_2, iCOS, iSIN, iOVF_CLR,
    output oVALID, oA, oB, oOVF
  );
endinterface

// File: rtl/fht_but_array.sv
// rtl/fht_but_array.sv - N_BUT-lane radix-2 FHT butterfly array, 3-stage pipeline with scaling, saturation and bank mixer
module fht_but_array #(
  parameter int D_BIT = 17,
  parameter int W_BIT = 12,
  parameter int N_BUT = 2
) (
  input  logic            iCLK,
  input  logic            iRESET,
  fht_but_array_if.slave  bus
);
  localparam int PW = D_BIT + W_BIT;      // one full-precision product
  localparam int SW = D_BIT + W_BIT + 1;  // sum of the two products
  localparam int EW = D_BIT + 2;          // butterfly outputs before saturation
  localparam logic signed [SW-1:0] RND     = SW'(2 ** (W_BIT - 3));
  localparam logic signed [EW-1:0] SAT_MAX = EW'(2 ** (D_BIT - 1) - 1);
  localparam logic signed [EW-1:0] SAT_MIN = -EW'(2 ** (D_BIT - 1));
  localparam logic [1:0] MODE_FIRST  = 2'd1;
  localparam logic [1:0] MODE_SECOND = 2'd2;

  logic signed [PW-1:0]    pc_d [N_BUT];
  logic signed [PW-1:0]    ps_d [N_BUT];
  logic signed [PW-1:0]    pc_q [N_BUT];
  logic signed [PW-1:0]    ps_q [N_BUT];
  logic signed [D_BIT-1:0] x0_s1_q [N_BUT];
  logic signed [D_BIT-1:0] x0_s2_q [N_BUT];
  logic signed [SW-1:0]    sum_d [N_BUT];
  logic signed [EW-1:0]    t_d [N_BUT];
  logic signed [EW-1:0]    t_q [N_BUT];
  logic signed [EW-1:0]    p_d [N_BUT];
  logic signed [EW-1:0]    q_d [N_BUT];
  logic signed [D_BIT-1:0] sp_d [N_BUT];
  logic signed [D_BIT-1:0] sq_d [N_BUT];
  logic [1:0]              mode_s1_q, mode_s2_q;
  logic                    scale_s1_q, scale_s2_q;
  logic                    vld_s1_q, vld_s2_q, vld_s3_q;
  logic [N_BUT*D_BIT-1:0]  a_d, b_d, a_q, b_q;
  logic                    clamp_d;
  logic                    ovf_q;

  // Stage 1 combinational: full-precision twiddle products per lane
  always_comb begin
    for (int k = 0; k < N_BUT; k++) begin
      pc_d[k] = PW'($signed(bus.iX_1[k*D_BIT +: D_BIT])) * PW'($signed(bus.iCOS[k*W_BIT +: W_BIT]));
      ps_d[k] = PW'($signed(bus.iX_2[k*D_BIT +: D_BIT])) * PW'($signed(bus.iSIN[k*W_BIT +: W_BIT]));
    end
  end

  // Stage 1 registers: products, X0 and the per-transaction mode/scale travelling with the data
  always_ff @(posedge iCLK) begin
    if (iRESET) vld_s1_q <= 1'b0;
    else        vld_s1_q <= bus.iVALID;
    mode_s1_q  <= bus.iMODE;
    scale_s1_q <= bus.iSCALE;
    for (int k = 0; k < N_BUT; k++) begin
      pc_q[k]    <= pc_d[k];
      ps_q[k]    <= ps_d[k];
      x0_s1_q[k] <= bus.iX_0[k*D_BIT +: D_BIT];
    end
  end

  // Stage 2 combinational: round half up and rescale the twiddle sum back to data units
  always_comb begin
    for (int k = 0; k < N_BUT; k++) begin
      sum_d[k] = SW'(pc_q[k]) + SW'(ps_q[k]) + RND;
      t_d[k]   = EW'(sum_d[k] >>> (W_BIT - 2));
    end
  end

  // Stage 2 registers: rotated term T and the delayed X0
  always_ff @(posedge iCLK) begin
    if (iRESET) vld_s2_q <= 1'b0;
    else        vld_s2_q <= vld_s1_q;
    mode_s2_q  <= mode_s1_q;
    scale_s2_q <= scale_s1_q;
    for (int k = 0; k < N_BUT; k++) begin
      t_q[k]     <= t_d[k];
      x0_s2_q[k] <= x0_s1_q[k];
    end
  end

  // Stage 3 combinational: butterfly, optional halving, saturation and pairwise bank mix
  always_comb begin
    clamp_d = 1'b0;
    a_d     = '0;
    b_d     = '0;
    for (int k = 0; k < N_BUT; k++) begin
      p_d[k] = EW'(x0_s2_q[k]) + t_q[k];
      q_d[k] = EW'(x0_s2_q[k]) - t_q[k];
      if (scale_s2_q) begin
        p_d[k] = (p_d[k] + EW'(1)) >>> 1;
        q_d[k] = (q_d[k] + EW'(1)) >>> 1;
      end
      if (p_d[k] > SAT_MAX) begin
        sp_d[k] = SAT_MAX[D_BIT-1:0];
        clamp_d = 1'b1;
      end else if (p_d[k] < SAT_MIN) begin
        sp_d[k] = SAT_MIN[D_BIT-1:0];
        clamp_d = 1'b1;
      end else begin
        sp_d[k] = p_d[k][D_BIT-1:0];
      end
      if (q_d[k] > SAT_MAX) begin
        sq_d[k] = SAT_MAX[D_BIT-1:0];
        clamp_d = 1'b1;
      end else if (q_d[k] < SAT_MIN) begin
        sq_d[k] = SAT_MIN[D_BIT-1:0];
        clamp_d = 1'b1;
      end else begin
        sq_d[k] = q_d[k][D_BIT-1:0];
      end
    end
    for (int j = 0; j < N_BUT / 2; j++) begin
      case (mode_s2_q)
        MODE_FIRST: begin
          a_d[(2*j)*D_BIT   +: D_BIT] = sp_d[2*j];
          b_d[(2*j)*D_BIT   +: D_BIT] = sp_d[2*j+1];
          a_d[(2*j+1)*D_BIT +: D_BIT] = sq_d[2*j];
          b_d[(2*j+1)*D_BIT +: D_BIT] = sq_d[2*j+1];
        end
        MODE_SECOND: begin
          a_d[(2*j)*D_BIT   +: D_BIT] = sp_d[2*j+1];
          b_d[(2*j)*D_BIT   +: D_BIT] = sp_d[2*j];
          a_d[(2*j+1)*D_BIT +: D_BIT] = sq_d[2*j+1];
          b_d[(2*j+1)*D_BIT +: D_BIT] = sq_d[2*j];
        end
        default: begin
          a_d[(2*j)*D_BIT   +: D_BIT] = sp_d[2*j];
          b_d[(2*j)*D_BIT   +: D_BIT] = sq_d[2*j];
          a_d[(2*j+1)*D_BIT +: D_BIT] = sp_d[2*j+1];
          b_d[(2*j+1)*D_BIT +: D_BIT] = sq_d[2*j+1];
        end
      endcase
    end
  end

  // Stage 3 registers: outputs hold while idle; overflow set wins over clear
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      vld_s3_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      vld_s3_q <= vld_s2_q;
      if (vld_s2_q) begin
        a_q <= a_d;
        b_q <= b_d;
      end
      if (vld_s2_q && clamp_d) ovf_q <= 1'b1;
      else if (bus.iOVF_CLR)   ovf_q <= 1'b0;
    end
  end

  assign bus.oVALID = vld_s3_q;
  assign bus.oA     = a_q;
  assign bus.oB     = b_q;
  assign bus.oOVF   = ovf_q;
endmodule
